// File: rtl/mbinit_sb_msg_tx_if.sv
// Sideband message transmitter bus: request side from the MBINIT FSM,
// serial frame and status side back to the FSM / sideband lane.
interface mbinit_sb_msg_tx_if #(
  parameter int SB_MSG_Width = 4
);
  logic                    i_tx_en;
  logic [SB_MSG_Width-1:0] i_encoded_SB_msg;
  logic                    i_msg_valid;
  logic                    o_sb_data;
  logic                    o_sb_data_valid;
  logic                    o_sb_busy;
  logic                    o_falling_edge_busy;
  logic                    o_overflow;
  logic [7:0]              o_tx_count;

  modport master (
    output i_tx_en,
    output i_encoded_SB_msg,
    output i_msg_valid,
    input  o_sb_data,
    input  o_sb_data_valid,
    input  o_sb_busy,
    input  o_falling_edge_busy,
    input  o_overflow,
    input  o_tx_count
  );

  modport slave (
    input  i_tx_en,
    input  i_encoded_SB_msg,
    input  i_msg_valid,
    output o_sb_data,
    output o_sb_data_valid,
    output o_sb_busy,
    output o_falling_edge_busy,
    output o_overflow,
    output o_tx_count
  );
endinterface

// File: rtl/mbinit_sb_msg_tx.sv
// Serialises encoded MBINIT sideband messages into start/data/parity/stop
// frames, with a one-entry pending slot and an enforced idle gap.
module mbinit_sb_msg_tx #(
  parameter int SB_MSG_Width = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic                  i_clk,
  input logic                  i_rst,
  mbinit_sb_msg_tx_if.slave    sb
);

  localparam int FL = SB_MSG_Width + 3;
  localparam int BW = $clog2(FL);
  localparam int W  = SB_MSG_Width;

  localparam logic [BW-1:0] BIT_LAST = BW'(FL - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [FL-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [3:0]    gap_q, gap_d;
  logic          pv_q, pv_d;
  logic [W-1:0]  pm_q, pm_d;
  logic [W-1:0]  last_q, last_d;
  logic          prev_q, prev_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          req;
  logic [W-1:0]  msg;

  function automatic logic [FL-1:0] mk_frame(
    input logic [W-1:0] m
  );
    return {1'b1, m, ^m, 1'b0};
  endfunction

  assign msg = sb.i_encoded_SB_msg;

  // Level-valid is turned into discrete requests: rising valid or new payload
  assign req = sb.i_tx_en & sb.i_msg_valid &
               (~prev_q | (msg != last_q));

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    pv_d    = pv_q & sb.i_tx_en;
    pm_d    = pm_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    last_d  = req ? msg : last_q;
    prev_d  = sb.i_msg_valid;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_SHIFT;
          sh_d    = mk_frame(msg);
          bit_d   = '0;
        end
      end

      S_SHIFT: begin
        sh_d  = {sh_q[FL-2:0], 1'b0};
        bit_d = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          state_d = S_GAP;
          gap_d   = '0;
          cnt_d   = cnt_q + 8'd1;
        end
        if (req) begin
          if (!pv_q) begin
            pv_d = 1'b1;
            pm_d = msg;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GAP_LAST) begin
          // Pending wins; a same-cycle request refills the freed slot
          if (pv_q && sb.i_tx_en) begin
            state_d = S_SHIFT;
            sh_d    = mk_frame(pm_q);
            bit_d   = '0;
            pv_d    = req;
            if (req) pm_d = msg;
          end else if (req) begin
            state_d = S_SHIFT;
            sh_d    = mk_frame(msg);
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (req) begin
          if (!pv_q) begin
            pv_d = 1'b1;
            pm_d = msg;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        pv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      pv_q    <= 1'b0;
      pm_q    <= '0;
      last_q  <= '0;
      prev_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      pv_q    <= pv_d;
      pm_q    <= pm_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sb.o_sb_busy           = (state_q == S_SHIFT);
  assign sb.o_sb_data_valid     = (state_q == S_SHIFT);
  assign sb.o_sb_data           = (state_q == S_SHIFT) & sh_q[FL-1];
  assign sb.o_falling_edge_busy = (state_q == S_GAP) & (gap_q == 4'd0);
  assign sb.o_overflow          = ovf_q;
  assign sb.o_tx_count          = cnt_q;

endmodule

// File: doc/mbinit_sb_msg_tx.md
MBINIT_SB_MSG_TX -- requirements
Module: mbinit_sb_msg_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SB_MSG_Width, 4, width of the encoded sideband message.
- GAP_CYCLES, 2, minimum idle cycles after each frame; legal range 1..15.
REQ-002 Ports, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_tx_en, in, 1, transmitter enable.
- i_encoded_SB_msg, in, SB_MSG_Width, encoded message from the PARAM/MBINIT FSM.
- i_msg_valid, in, 1, level-valid for i_encoded_SB_msg; may be held for many cycles.
- o_sb_data, out, 1, serial frame bit.
- o_sb_data_valid, out, 1, o_sb_data is a live frame bit.
- o_sb_busy, out, 1, frame in flight; drives the FSM's i_sb_busy.
- o_falling_edge_busy, out, 1, one-cycle pulse at frame end; drives the FSM's i_falling_edge_busy.
- o_overflow, out, 1, sticky flag: a request was dropped.
- o_tx_count, out, 8, frames completed; wraps 255 -> 0.

Function
REQ-003 The frame is FRAME_LEN = SB_MSG_Width+3 bits, sent in this order:
- start bit 1;
- message bits, MSB first;
- even-parity bit, equal to the XOR of all message bits;
- stop bit 0.
REQ-004 A new request is registered whenever i_msg_valid=1 and either:
- i_msg_valid was 0 in the previous cycle, or
- i_encoded_SB_msg differs from the last captured message.
REQ-005 A valid that is held with an unchanged message generates no further requests.
REQ-006 The FSM has states IDLE, SHIFT and GAP.
REQ-007 In IDLE, a request seen at rising edge N is captured at N.
- SHIFT is entered at N.
- From N+1 through N+FRAME_LEN: o_sb_busy=1, o_sb_data_valid=1, and o_sb_data carries one frame bit per cycle.
REQ-008 After the last bit, the state becomes GAP.
- In the first GAP cycle: o_sb_busy=0, o_sb_data_valid=0, o_falling_edge_busy=1 for exactly one cycle.
- o_tx_count increments in that same cycle.
REQ-009 GAP lasts exactly GAP_CYCLES cycles. On exit:
- pending slot full -> SHIFT with the pending message, and the first bit appears in the next cycle;
- otherwise -> IDLE.
REQ-010 A request arriving in SHIFT or GAP is stored in a one-entry pending slot if the slot is empty.
REQ-011 If the slot is full, the new request is dropped, the slot keeps its message, and o_overflow is set.
REQ-012 Simultaneous events:
- A request in the same cycle as GAP exit while the slot is full: the pending message is sent first, and the new request takes the freed slot (no overflow).
- A request in the same cycle as GAP exit while the slot is empty: the request goes straight to SHIFT.
REQ-013 When i_tx_en=0:
- new requests are ignored;
- the pending slot is cleared;
- a frame already in SHIFT completes normally, including its GAP and the o_falling_edge_busy pulse;
- after that GAP the state returns to IDLE.
REQ-014 While idle, o_sb_data=0 and o_sb_data_valid=0.
REQ-015 o_sb_busy is never high in IDLE or GAP.
REQ-016 o_falling_edge_busy is high only in the first GAP cycle.
REQ-017 o_overflow clears only on reset.

Reset
REQ-018 When i_rst is asserted, the block returns immediately (asynchronously) to these values:
- state IDLE, pending slot empty, last-captured message 0, previous-valid register 0;
- all outputs 0, including o_tx_count=0 and o_overflow=0.
REQ-019 Reset asserted in the middle of a frame aborts it: no falling-edge pulse, no count increment.
REQ-020 After reset is released, the first request is honoured on the next rising edge.

Verification
REQ-021 Single frame (W=4, GAP=2): i_msg_valid held for 10 cycles with msg 4'b0001 -> required response:
- o_sb_data = 1,0,0,0,1,1,0 over 7 busy cycles;
- one falling-edge pulse;
- o_tx_count=1;
- no second frame.
REQ-022 Message change under a held valid: 0001 held, then 0010 while still valid -> required response:
- second frame is 1,0,0,1,0,1,0;
- it starts 3 cycles after the first frame's last bit.
REQ-023 Overflow: three distinct messages within one frame time -> required response:
- the first is sent, the second is pending, the third is dropped;
- o_overflow=1 and stays 1;
- o_tx_count=2 after both frames complete.
REQ-024 Simultaneous event: request in the GAP-exit cycle while the pending slot is full -> required response:
- three frames in arrival order;
- o_overflow=0.
REQ-025 Reset mid-frame: i_rst pulsed at bit 3 -> required response:
- all outputs are 0 immediately;
- no pulse;
- o_tx_count=0;
- a new request afterwards transmits normally.
REQ-026 Disable: i_tx_en dropped at bit 2 with a request pending -> required response:
- the current frame completes;
- the pending request is discarded;
- o_tx_count=1;
- the FSM returns to IDLE.
